// File: rtl/spimaster_multi.sv
// spimaster_multi -- parametrised SPI master.
//
// Shifts one word of 1..WIDTH bits per frame in any CPOL/CPHA mode, with
// a programmable SCLK half-period of div+1 clkin cycles. Each frame runs
// through SETUP, SHIFT, HOLD and GAP phases, so chip-select timing around
// SCLK is explicit. Chip selects can be driven per frame (autocs) or
// directly from cs_mask.
//
// Optional feature: define SPIMASTER_LSBFIRST_EN to add the lsbfirst input.
// When it is undefined, the core always shifts MSB-first.
//
// Ports:
//   clkin, rst       system clock, asynchronous active-high reset
//   cpol, cpha       SPI mode (captured at go)
//   cspol            chip-select idle level
//   autocs           1 = per-frame CS, 0 = cs follows cs_mask continuously
//   cs_mask          chip-select lines to assert
//   div              SCLK half-period minus one, in clkin cycles
//   nbits            word length (0 or > WIDTH means WIDTH)
//   go               start request, level-sampled while idle
//   lsbfirst         (optional) shift LSB-first
//   busy, done       frame in progress / one-cycle end-of-frame pulse
//   data_i, data_o   transmit word / received word, both right-aligned
//   mosi, miso, sclk, cs   SPI pins
module spimaster_multi #(
   parameter int WIDTH = 16,
   parameter int DIVW  = 8,
   parameter int NCS   = 2,
   parameter int LENW  = 5
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             cspol,
   input  logic             autocs,
   input  logic [NCS-1:0]   cs_mask,
   input  logic [DIVW-1:0]  div,
   input  logic [LENW-1:0]  nbits,
   input  logic             go,
`ifdef SPIMASTER_LSBFIRST_EN
   input  logic             lsbfirst,
`endif
   output logic             busy,
   output logic             done,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             mosi,
   input  logic             miso,
   output logic             sclk,
   output logic [NCS-1:0]   cs
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state_q;
   logic [DIVW-1:0]  cnt_q, div_q;
   logic [LENW:0]    edg_q;
   logic [LENW-1:0]  n_q, txk_q, rxk_q;
   logic [WIDTH-1:0] tx_q, rx_q, data_o_q;
   logic             cpol_q, cpha_q, lsb_q;
   logic [NCS-1:0]   cs_q;
   logic             busy_q, done_q, mosi_q, sclk_q;

   logic             lsb_d;
   logic [LENW-1:0]  n_d;
   logic [NCS-1:0]   cs_idle;
   logic             edge_now, last_now, smp_now;

   // Wire position of the k-th bit on the wire within an n-bit word.
   function automatic logic [LENW-1:0] bitpos(input logic [LENW-1:0] k,
                                              input logic [LENW-1:0] n,
                                              input logic            lsb);
      return lsb ? k : (n - LENW'(1) - k);
   endfunction

   function automatic logic bit_at(input logic [WIDTH-1:0] w,
                                   input logic [LENW-1:0]  p);
      logic [WIDTH-1:0] t;
      t = w >> p;
      return t[0];
   endfunction

   always_comb begin
`ifdef SPIMASTER_LSBFIRST_EN
      lsb_d = lsbfirst;
`else
      lsb_d = 1'b0;
`endif
      n_d      = (nbits == '0 || nbits > LENW'(WIDTH)) ? LENW'(WIDTH) : nbits;
      cs_idle  = {NCS{cspol}};
      // The SETUP->SHIFT transition is itself the first (leading) edge.
      // The remaining 2N-1 toggles happen inside SHIFT.
      edge_now = (cnt_q == '0) &&
                 ((state_q == SETUP) || (state_q == SHIFT && edg_q != '0));
      last_now = (state_q == SHIFT) && (edg_q == (LENW+1)'(1));
      // Sample on the leading edge when cpha=0 and on the trailing edge when cpha=1.
      smp_now  = (sclk_q == cpol_q) ^ cpha_q;
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= '0;
         edg_q    <= '0;
         n_q      <= '0;
         txk_q    <= '0;
         rxk_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         data_o_q <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsb_q    <= 1'b0;
         cs_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mosi_q   <= 1'b0;
         sclk_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!autocs) cs_q <= cs_idle ^ cs_mask;
         if (cnt_q != '0) cnt_q <= cnt_q - DIVW'(1);

         unique case (state_q)
            IDLE: begin
               sclk_q <= cpol;
               if (autocs) cs_q <= cs_idle;
               if (go) begin
                  state_q <= SETUP;
                  busy_q  <= 1'b1;
                  cnt_q   <= div;
                  div_q   <= div;
                  n_q     <= n_d;
                  tx_q    <= data_i;
                  rx_q    <= '0;
                  rxk_q   <= '0;
                  cpol_q  <= cpol;
                  cpha_q  <= cpha;
                  lsb_q   <= lsb_d;
                  if (autocs) cs_q <= cs_idle ^ cs_mask;
                  // With cpha=0 the first bit must be on mosi before the leading edge.
                  if (!cpha) begin
                     mosi_q <= bit_at(data_i, bitpos('0, n_d, lsb_d));
                     txk_q  <= LENW'(1);
                  end else begin
                     txk_q  <= '0;
                  end
               end
            end
            SETUP: begin
               if (cnt_q == '0) begin
                  state_q <= SHIFT;
                  cnt_q   <= div_q;
                  edg_q   <= {n_q, 1'b0} - (LENW+1)'(1);
               end
            end
            SHIFT: begin
               if (cnt_q == '0) begin
                  cnt_q <= div_q;
                  if (edg_q != '0) begin
                     edg_q <= edg_q - (LENW+1)'(1);
                  end else begin
                     state_q <= HOLD;
                     sclk_q  <= cpol_q;
                  end
               end
            end
            HOLD: begin
               if (cnt_q == '0) begin
                  state_q <= GAP;
                  cnt_q   <= div_q;
                  if (autocs) cs_q <= cs_idle;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  data_o_q <= rx_q;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Each SCLK edge either samples miso or launches the next mosi bit.
         // After the final trailing edge, mosi keeps the last bit through HOLD.
         if (edge_now) begin
            sclk_q <= ~sclk_q;
            if (smp_now) begin
               if (miso) rx_q <= rx_q | (WIDTH'(1) << bitpos(rxk_q, n_q, lsb_q));
               rxk_q <= rxk_q + LENW'(1);
            end else if (!last_now) begin
               mosi_q <= bit_at(tx_q, bitpos(txk_q, n_q, lsb_q));
               txk_q  <= txk_q + LENW'(1);
            end
         end
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign data_o = data_o_q;
   assign mosi   = mosi_q;
   assign sclk   = sclk_q;
   assign cs     = cs_q;

endmodule
